mem_port_arbiter: RTL and testbench

- Shares the core's single external memory port between two requesters: instruction-cache block refills (multi-beat bursts) and data-memory single-word loads/stores.
- Sits between the pipelined core/instruction cache and the memory model/bus.
- Round-robin arbitration; one transaction in flight at a time.
- Sequences refill bursts with a beat counter and returns per-beat data for direct write into the icache line.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the icache/data-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    IC_BURST,
    DM_ACCESS
  } arb_state_t;

  typedef enum logic {
    GRANT_IC,
    GRANT_DM
  } grant_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between icache refill bursts and data accesses.
// Optional MEM_ARB_TIMEOUT_EN adds a wait-timeout abort with a sticky timeout_err_o flag.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BLOCK_WORDS = 4,
  parameter int ADDR_WIDTH  = 32
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
`ifdef MEM_ARB_TIMEOUT_EN
  output logic                           timeout_err_o,
`endif
  input  logic                           ic_req_i,
  input  logic [ADDR_WIDTH-1:0]          ic_addr_i,
  output logic [31:0]                    ic_rdata_o,
  output logic                           ic_rvalid_o,
  output logic [$clog2(BLOCK_WORDS)-1:0] ic_beat_o,
  output logic                           ic_done_o,
  input  logic                           dm_req_i,
  input  logic                           dm_we_i,
  input  logic [ADDR_WIDTH-1:0]          dm_addr_i,
  input  logic [31:0]                    dm_wdata_i,
  output logic [31:0]                    dm_rdata_o,
  output logic                           dm_done_o,
  output logic                           mem_req_o,
  output logic                           mem_we_o,
  output logic [ADDR_WIDTH-1:0]          mem_addr_o,
  output logic [31:0]                    mem_wdata_o,
  input  logic                           mem_ready_i,
  input  logic [31:0]                    mem_rdata_i
);

  localparam int BEAT_W = $clog2(BLOCK_WORDS);
  localparam logic [ADDR_WIDTH-1:0] BLK_MASK  = ~ADDR_WIDTH'(BLOCK_WORDS * WORD_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(WORD_BYTES - 1);
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

  arb_state_t              state_q, state_d;
  grant_t                  last_q, last_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    we_q;
  logic [31:0]             wdata_q;
  logic                    grant_ic, grant_dm;
  logic                    abort;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [WAIT_W-1:0] wait_q;
  logic              err_q;

  assign abort         = (state_q != IDLE) && !mem_ready_i && (wait_q == WAIT_W'(TIMEOUT_CYCLES));
  assign timeout_err_o = err_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if ((state_q == IDLE) || mem_ready_i || abort) wait_q <= '0;
      else                                           wait_q <= wait_q + 1'b1;
      if (abort) err_q <= 1'b1;
    end
  end
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      last_q  <= GRANT_DM;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  // Request fields are captured only on the grant edge; requesters may change them afterwards.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (grant_ic) begin
      addr_q  <= ic_addr_i & BLK_MASK;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (grant_dm) begin
      addr_q  <= dm_addr_i & WORD_MASK;
      we_q    <= dm_we_i;
      wdata_q <= dm_wdata_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    beat_d      = beat_q;
    grant_ic    = 1'b0;
    grant_dm    = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    ic_rvalid_o = 1'b0;
    ic_rdata_o  = '0;
    ic_done_o   = 1'b0;
    dm_done_o   = 1'b0;
    dm_rdata_o  = '0;
    case (state_q)
      IDLE: begin
        if (ic_req_i && (!dm_req_i || (last_q == GRANT_DM))) begin
          grant_ic = 1'b1;
          state_d  = IC_BURST;
        end else if (dm_req_i) begin
          grant_dm = 1'b1;
          state_d  = DM_ACCESS;
        end
      end
      IC_BURST: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          ic_rvalid_o = 1'b1;
          ic_rdata_o  = mem_rdata_i;
          beat_d      = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            ic_done_o = 1'b1;
            beat_d    = '0;
            last_d    = GRANT_IC;
            state_d   = IDLE;
          end
        end else if (abort) begin
          ic_done_o = 1'b1;
          beat_d    = '0;
          last_d    = GRANT_IC;
          state_d   = IDLE;
        end
      end
      DM_ACCESS: begin
        mem_req_o = 1'b1;
        mem_we_o  = we_q;
        if (mem_ready_i || abort) begin
          dm_done_o  = 1'b1;
          dm_rdata_o = (mem_ready_i && !we_q) ? mem_rdata_i : '0;
          last_d     = GRANT_DM;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Burst base has its low offset bits cleared, so OR-ing the beat offset equals adding it.
  assign mem_addr_o  = addr_q | ADDR_WIDTH'({beat_q, 2'b00});
  assign mem_wdata_o = wdata_q;
  assign ic_beat_o   = beat_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic vs a transaction model.
module tb_mem_port_arbiter;

  localparam int BW = 4;
  localparam int AW = 32;

  logic                  clk_i = 1'b0;
  logic                  reset_i = 1'b1;
  logic                  ic_req_i = 1'b0;
  logic [AW-1:0]         ic_addr_i = '0;
  logic [31:0]           ic_rdata_o;
  logic                  ic_rvalid_o;
  logic [$clog2(BW)-1:0] ic_beat_o;
  logic                  ic_done_o;
  logic                  dm_req_i = 1'b0;
  logic                  dm_we_i = 1'b0;
  logic [AW-1:0]         dm_addr_i = '0;
  logic [31:0]           dm_wdata_i = '0;
  logic [31:0]           dm_rdata_o;
  logic                  dm_done_o;
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [AW-1:0]         mem_addr_o;
  logic [31:0]           mem_wdata_o;
  logic                  mem_ready_i = 1'b0;
  logic [31:0]           mem_rdata_i = '0;
`ifdef MEM_ARB_TIMEOUT_EN
  logic                  timeout_err_o;
`endif

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.BLOCK_WORDS(BW), .ADDR_WIDTH(AW)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
`ifdef MEM_ARB_TIMEOUT_EN
    .timeout_err_o(timeout_err_o),
`endif
    .ic_req_i    (ic_req_i),
    .ic_addr_i   (ic_addr_i),
    .ic_rdata_o  (ic_rdata_o),
    .ic_rvalid_o (ic_rvalid_o),
    .ic_beat_o   (ic_beat_o),
    .ic_done_o   (ic_done_o),
    .dm_req_i    (dm_req_i),
    .dm_we_i     (dm_we_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_rdata_o  (dm_rdata_o),
    .dm_done_o   (dm_done_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ready_i (mem_ready_i),
    .mem_rdata_i (mem_rdata_i)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level model: one in-flight transfer, who was served last, and a grant history.
  bit          m_busy = 1'b0;
  bit          m_is_dm = 1'b0;
  bit          m_last_dm = 1'b1;
  logic [31:0] m_base = '0;
  int          m_beat = 0;
  bit          m_we = 1'b0;
  logic [31:0] m_wdata = '0;
  int          grant_log[$];
  bit          hold_reqs = 1'b0;
  int          n_ic_done = 0;
  int          n_dm_done = 0;
  logic [31:0] last_dm_rdata = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called just after a falling edge with inputs already driven; checks, then advances one clock.
  task automatic step();
    bit fire, ic_done_e, dm_done_e;
    #2;
    fire      = m_busy && mem_ready_i;
    ic_done_e = fire && !m_is_dm && (m_beat == BW - 1);
    dm_done_e = fire && m_is_dm;
    check("mem_req", mem_req_o, m_busy);
    check("strobes", {ic_rvalid_o, ic_done_o, dm_done_o}, {fire && !m_is_dm, ic_done_e, dm_done_e});
    if (m_busy) begin
      check("mem_addr", mem_addr_o, m_base + 32'(m_beat * 4));
      check("mem_we", mem_we_o, m_is_dm && m_we);
      if (m_is_dm && m_we) check("mem_wdata", mem_wdata_o, m_wdata);
    end else begin
      check("mem_we_idle", mem_we_o, 1'b0);
    end
    if (fire && !m_is_dm) begin
      check("ic_beat", ic_beat_o, m_beat);
      check("ic_rdata", ic_rdata_o, mem_rdata_i);
    end
    if (dm_done_e) begin
      check("dm_rdata", dm_rdata_o, m_we ? 32'h0 : mem_rdata_i);
      last_dm_rdata = dm_rdata_o;
    end
    if (ic_done_e) n_ic_done++;
    if (dm_done_e) n_dm_done++;

    if (reset_i) begin
      m_busy = 1'b0;
      m_beat = 0;
      m_last_dm = 1'b1;
    end else if (fire) begin
      if (m_is_dm) begin
        m_busy = 1'b0;
        m_last_dm = 1'b1;
      end else if (m_beat == BW - 1) begin
        m_busy = 1'b0;
        m_beat = 0;
        m_last_dm = 1'b0;
      end else begin
        m_beat++;
      end
    end else if (!m_busy) begin
      if (ic_req_i && (!dm_req_i || m_last_dm)) begin
        m_busy = 1'b1; m_is_dm = 1'b0; m_beat = 0;
        m_base = ic_addr_i & ~32'(BW * 4 - 1);
        grant_log.push_back(0);
      end else if (dm_req_i) begin
        m_busy = 1'b1; m_is_dm = 1'b1; m_beat = 0;
        m_base = dm_addr_i & ~32'h3;
        m_we = dm_we_i; m_wdata = dm_wdata_i;
        grant_log.push_back(1);
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
    if (!hold_reqs) begin
      if (ic_done_e) ic_req_i = 1'b0;
      if (dm_done_e) dm_req_i = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_a[4];
    int ic_before, dm_before;
    exp_a = '{32'h1230, 32'h1234, 32'h1238, 32'h123C};

    @(posedge clk_i);
    @(negedge clk_i);
    do_reset();
    #1;
    check("rst_ctrl", {mem_req_o, mem_we_o, ic_rvalid_o, ic_done_o, dm_done_o}, 5'b0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_wdata", mem_wdata_o, 32'h0);
    check("rst_ic_rdata", ic_rdata_o, 32'h0);
    check("rst_dm_rdata", dm_rdata_o, 32'h0);
    check("rst_beat", ic_beat_o, 0);
    @(negedge clk_i);

    // IC-only burst from a mid-block address with memory always ready
    ic_before = n_ic_done;
    ic_req_i = 1'b1; ic_addr_i = 32'h0000_1234; mem_ready_i = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      mem_rdata_i = $urandom;
      #1;
      check("ic1_addr", mem_addr_o, exp_a[i]);
      check("ic1_beat", ic_beat_o, i);
      step();
    end
    check("ic1_done_cnt", n_ic_done - ic_before, 1);
    check("ic1_req_low", mem_req_o, 1'b0);

    // Simultaneous requests out of reset: IC first, then DM load
    do_reset();
    grant_log.delete();
    ic_req_i = 1'b1; ic_addr_i = 32'h0000_4000;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h100;
    mem_rdata_i = 32'hDEADBEEF; mem_ready_i = 1'b1;
    for (int k = 0; k < 30 && (ic_req_i || dm_req_i); k++) step();
    check("tie_len", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      check("tie_first", grant_log[0], 0);
      check("tie_second", grant_log[1], 1);
    end
    check("tie_dm_rdata", last_dm_rdata, 32'hDEADBEEF);

    // Both held continuously: grants must alternate
    grant_log.delete();
    hold_reqs = 1'b1;
    ic_req_i = 1'b1; dm_req_i = 1'b1; dm_we_i = 1'b1; dm_wdata_i = 32'h1234_5678;
    for (int k = 0; k < 60 && (grant_log.size() < 4 || m_busy); k++) begin
      mem_rdata_i = $urandom;
      step();
    end
    hold_reqs = 1'b0;
    ic_req_i = 1'b0; dm_req_i = 1'b0;
    step();
    check("alt_count", grant_log.size() >= 4, 1'b1);
    if (grant_log.size() >= 4)
      check("alt_order", {grant_log[0][0], grant_log[1][0], grant_log[2][0], grant_log[3][0]}, 4'b0101);

    // Store with a 5-cycle ready delay: request fields held stable throughout
    dm_before = n_dm_done;
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h200; dm_wdata_i = 32'hCAFEF00D;
    mem_ready_i = 1'b0; mem_rdata_i = 32'h5555_AAAA;
    step();
    dm_addr_i = 32'hFFFF_FFF0; dm_wdata_i = 32'h0;
    for (int i = 0; i < 6; i++) begin
      mem_ready_i = (i == 5);
      #1;
      check("st_hold", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}, {1'b1, 1'b1, 32'h200, 32'hCAFEF00D});
      check("st_done", dm_done_o, (i == 5));
      step();
    end
    check("st_done_cnt", n_dm_done - dm_before, 1);
    check("st_rdata", last_dm_rdata, 32'h0);

    // Reset during beat 2 abandons the burst; a new one restarts at beat 0
    ic_before = n_ic_done;
    ic_req_i = 1'b1; ic_addr_i = 32'h0000_8010; mem_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    #1;
    check("rst_mid_req", mem_req_o, 1'b0);
    check("rst_mid_done", ic_done_o, 1'b0);
    step();
    #1;
    check("rst_restart_beat", {mem_req_o, ic_beat_o}, {1'b1, 2'd0});
    for (int k = 0; k < 10 && ic_req_i; k++) step();
    check("rst_mid_done_cnt", n_ic_done - ic_before, 1);

    // Randomized traffic with waits, dropped requests, field churn and occasional reset
    for (int c = 0; c < 1500; c++) begin
      mem_ready_i = ($urandom_range(0, 99) < 60);
      mem_rdata_i = $urandom;
      if (m_busy && !m_is_dm) begin
        ic_addr_i = $urandom;
        if ($urandom_range(0, 19) == 0) ic_req_i = 1'b0;
      end
      if (m_busy && m_is_dm) begin
        dm_addr_i = $urandom; dm_wdata_i = $urandom; dm_we_i = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 19) == 0) dm_req_i = 1'b0;
      end
      if (!ic_req_i && !(m_busy && !m_is_dm) && $urandom_range(0, 5) == 0) begin
        ic_req_i = 1'b1; ic_addr_i = $urandom;
      end
      if (!dm_req_i && !(m_busy && m_is_dm) && $urandom_range(0, 5) == 0) begin
        dm_req_i = 1'b1; dm_addr_i = $urandom; dm_wdata_i = $urandom;
        dm_we_i = 1'($urandom_range(0, 1));
      end
      reset_i = ($urandom_range(0, 299) == 0);
      step();
    end
    reset_i = 1'b0;
    ic_req_i = 1'b0; dm_req_i = 1'b0;
    do_reset();

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never ready: abort after the wait limit, sticky error until reset
    begin
      int early;
      early = 0;
      dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h40; mem_ready_i = 1'b0;
      @(negedge clk_i);
      for (int i = 0; i < 255; i++) begin
        #1;
        if (dm_done_o || !mem_req_o) early++;
        @(negedge clk_i);
      end
      check("to_no_early_done", early, 0);
      #1;
      check("to_done", {dm_done_o, dm_rdata_o}, {1'b1, 32'h0});
      @(negedge clk_i);
      dm_req_i = 1'b0;
      #1;
      check("to_err_set", {timeout_err_o, mem_req_o}, 2'b10);
      repeat (3) @(negedge clk_i);
      #1;
      check("to_err_sticky", timeout_err_o, 1'b1);
      reset_i = 1'b1;
      @(negedge clk_i);
      reset_i = 1'b0;
      #1;
      check("to_err_clear", timeout_err_o, 1'b0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
